// File: rtl/dwt_line_ctrl.sv
// dwt_line_ctrl: line sequencer for the folded two-level 1-D DWT core
// Ports: sys_clk, sys_rst (async active-low); start/abort line control;
//   s_valid/s_data/s_ready upstream samples; core_rst_n/core_data/core_sel/core_fold drive the core,
//   core_high/core_low its results; m_valid/m_data/m_band tagged coefficients (00=H1 01=H2 10=L2);
//   busy/done/underrun status; h1_cnt/h2_cnt/l2_cnt per-band beat counts.
// Define DWT_CTRL_STATS_EN to build the beat counters; otherwise they read 0.
module dwt_line_ctrl #(
  parameter int LINE_LEN   = 32,
  parameter int DATA_W     = 8,
  parameter int PIPE_LAT   = 4,
  parameter int FOLD_START = 9,
  parameter int FLUSH_CYC  = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              core_rst_n,
  output logic [DATA_W-1:0] core_data,
  output logic              core_sel,
  output logic              core_fold,
  input  logic [DATA_W-1:0] core_high,
  input  logic [DATA_W-1:0] core_low,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        m_band,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic [15:0]       h1_cnt,
  output logic [15:0]       h2_cnt,
  output logic [15:0]       l2_cnt
);
  localparam int CW = $clog2(LINE_LEN + PIPE_LAT + FLUSH_CYC) + 1;
  typedef enum logic [2:0] {IDLE, FLUSH, FEED, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] j;
  logic run, win, go;
  // cnt is the cycle index k through FEED and DRAIN; j is the output index k-PIPE_LAT
  assign go = state == IDLE && start;
  assign run = state == FEED || state == DRAIN;
  assign win = run && cnt >= CW'(PIPE_LAT);
  assign j = 2'(cnt - CW'(PIPE_LAT));
  always_comb begin
    state_nx = state;
    cnt_nx = cnt + 1'b1;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (start) state_nx = FLUSH;
      end
      FLUSH: if (cnt == CW'(FLUSH_CYC - 1)) begin
        state_nx = FEED;
        cnt_nx = '0;
      end
      FEED: if (cnt == CW'(LINE_LEN - 1)) state_nx = DRAIN;
      DRAIN: if (cnt == CW'(LINE_LEN + PIPE_LAT - 1)) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (abort && (state == FLUSH || run)) state_nx = DONE;
    s_ready = state == FEED;
    core_rst_n = run;
    core_data = state == FEED && s_valid ? s_data : '0;
    core_sel = run ? ~cnt[0] : 1'b1;
    core_fold = run && cnt >= CW'(FOLD_START);
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge sys_clk or negedge sys_rst)
    if (!sys_rst) begin
      state <= IDLE;
      cnt <= '0;
      underrun <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_band <= 2'b00;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      underrun <= go ? 1'b0 : underrun | (state == FEED && !s_valid);
      m_valid <= win && !abort;
      m_data <= !win ? '0 : (j[0] || j[1]) ? core_high : core_low;
      m_band <= !win ? 2'b00 : j[0] ? 2'b00 : j[1] ? 2'b01 : 2'b10;
    end
`ifdef DWT_CTRL_STATS_EN
  always_ff @(posedge sys_clk or negedge sys_rst)
    if (!sys_rst) begin
      h1_cnt <= '0;
      h2_cnt <= '0;
      l2_cnt <= '0;
    end else if (go) begin
      h1_cnt <= '0;
      h2_cnt <= '0;
      l2_cnt <= '0;
    end else if (m_valid) begin
      h1_cnt <= h1_cnt + 16'(m_band == 2'b00);
      h2_cnt <= h2_cnt + 16'(m_band == 2'b01);
      l2_cnt <= l2_cnt + 16'(m_band == 2'b10);
    end
`else
  assign h1_cnt = '0;
  assign h2_cnt = '0;
  assign l2_cnt = '0;
`endif
endmodule

// File: doc/dwt_line_ctrl.md
Name: dwt_line_ctrl

Overview:
- Sequencer for the folded 1-D two-level DWT core; one line of LINE_LEN samples per start pulse.
- Drives the core's reset, input sample and the phase and fold controls. Captures the core's high/low outputs and tags each valid output with its sub-band.
- Sits between the line buffer (valid/ready source) and the coefficient writer.

Parameters:
LINE_LEN, 32, samples per line; power of two, ≥8.
DATA_W, 8, sample/coefficient width.
PIPE_LAT, 4, cycles from first fed sample to first valid core output.
FOLD_START, 9, feed index at which fold select asserts.
FLUSH_CYC, 2, cycles core reset held low before feeding.

Ports:
sys_clk  in  1  clock
sys_rst  in  1  asynchronous active-low reset
start  in  1  pulse; begin a line (ignored unless IDLE)
abort  in  1  pulse; terminate current line
s_valid  in  1  upstream sample valid
s_data  in  DATA_W  upstream sample
s_ready  out  1  sample accepted when s_valid&s_ready
core_rst_n  out  1  to core DWT_rst / reset
core_data  out  DATA_W  sample to core
core_sel  out  1  even/odd phase
core_fold  out  1  fold-register select enable
core_high  in  DATA_W  core high-pass output
core_low  in  DATA_W  core low-pass output
m_valid  out  1  coefficient valid (no backpressure)
m_data  out  DATA_W  coefficient
m_band  out  2  00=H1, 01=H2, 10=L2
busy  out  1  not IDLE
done  out  1  one-cycle pulse at line end
underrun  out  1  sticky per line; gap in s_valid during FEED
h1_cnt, h2_cnt, l2_cnt  out  16 each  stats (see Optional Feature)

Behaviour:
- Reset (async, sys_rst=0): state IDLE. All outputs 0, except core_rst_n=0 and core_sel=1. Counters 0.
- States: IDLE -> FLUSH -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE: core_rst_n=0, s_ready=0. start=1 -> FLUSH; clear underrun and counters.
- FLUSH: core_rst_n=0 for FLUSH_CYC cycles, then FEED.
- FEED: core_rst_n=1, s_ready=1, exactly LINE_LEN cycles, feed index f=0..LINE_LEN-1.
  - core_data = s_data if s_valid, else 0 with underrun set.
  - Core is free-running and never stalls.
- DRAIN: PIPE_LAT cycles, core_data=0, s_ready=0. Then DONE.
- DONE: done=1 for one cycle, core_rst_n=0, then IDLE.
- core_sel: 1 at f=0, toggles every cycle through FEED and DRAIN; held 1 otherwise.
- core_fold: 1 when in FEED/DRAIN and cycle index ≥FOLD_START; else 0.
- Output window: cycle index k counts from the first FEED cycle. m_valid=1 for k in [PIPE_LAT, PIPE_LAT+LINE_LEN). Output index j=k-PIPE_LAT.
- Band mapping (m_data registered, one cycle after core output sampled):
  - j odd -> core_high, band 00.
  - j%4==2 -> core_high, band 01.
  - j%4==0 -> core_low, band 10.
  - Per line: LINE_LEN/2 H1, LINE_LEN/4 H2, LINE_LEN/4 L2.
- abort in FLUSH/FEED/DRAIN: next cycle DONE, m_valid forced 0, done pulses; underrun retained.
- start while busy: ignored. start and abort together in IDLE: start wins.
- Async reset mid-line: immediate return to IDLE values; no done pulse.
- Counters wrap modulo width; no saturation.

Optional Feature:
DWT_CTRL_STATS_EN:
- Defined: h1_cnt/h2_cnt/l2_cnt increment per tagged m_valid beat. They clear on start and wrap at 16 bits.
- Undefined: the three ports are tied to 0 and no counter logic is built.

Test Plan:
- Reset release, no start -> core_rst_n=0, core_sel=1, busy=0, m_valid=0 indefinitely.
- start with contiguous ramp s_data=0..31, s_valid=1 -> s_ready high exactly 32 cycles after 2 flush cycles. m_valid exactly 32 beats beginning 4 cycles after the first feed plus 1 register cycle. Bands 10,00,01,00 repeating. done once; underrun=0.
- Same line with s_valid=0 at f=5 -> core_data=0 that cycle, underrun=1 until next start, still 32 output beats.
- abort at f=10 -> next cycle DONE, done=1, m_valid=0 thereafter, back to IDLE after 1 cycle.
- start pulse at f=3 of a running line -> ignored; total feed cycles still 32.
- STATS_EN build, two back-to-back lines -> after each, h1_cnt=16, h2_cnt=8, l2_cnt=8. Without macro, all read 0.
